// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// MC_BNE_EN adds the BRANCHNE state used by bne.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
`ifdef MC_BNE_EN
    ,
    S_BRANCHNE = 4'd12
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop plus the instruction funct field to an ALU operation.
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore-FSM control unit for a multicycle MIPS datapath.
// Define MC_BNE_EN to add bne support through the BRANCHNE state.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       lord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       branchne;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // op is consulted live in DECODE and MEMADR; nothing about it is stored.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BRANCHNE;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    memwrite = 1'b0;
    lord     = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchne = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: lord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        lord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BRANCHNE: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        branchne = 1'b1;
      end
`endif
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

  assign pcen  = pcwrite | (branch & zero) | (branchne & ~zero);
  assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected state/output pairs are queued per instruction and checked cycle by cycle.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [14:0] outs;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memwrite   (memwrite),
    .lord       (lord),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .state      (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] exp_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Field order: memwrite lord irwrite regdst memtoreg regwrite alusrca alusrcb alucontrol pcen pcsrc
  function automatic logic [14:0] exp_outs(input logic [3:0] st, input logic [5:0] fn, input logic z);
    logic mw, ld, ir, rd, mr, rw, sa, pe;
    logic [1:0] sb_, ps;
    logic [2:0] ac;
    {mw, ld, ir, rd, mr, rw, sa, pe} = 8'b0;
    sb_ = 2'b00;
    ps  = 2'b00;
    ac  = 3'b010;
    case (st)
      4'd0:  begin ir = 1'b1; sb_ = 2'b01; pe = 1'b1; end
      4'd1:  sb_ = 2'b11;
      4'd2:  begin sa = 1'b1; sb_ = 2'b10; end
      4'd3:  ld = 1'b1;
      4'd4:  begin rw = 1'b1; mr = 1'b1; end
      4'd5:  begin ld = 1'b1; mw = 1'b1; end
      4'd6:  begin sa = 1'b1; ac = exp_alu(fn); end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
      4'd9:  begin sa = 1'b1; sb_ = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pe = 1'b1; end
      4'd12: begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = ~z; end
      default: ;
    endcase
    return {mw, ld, ir, rd, mr, rw, sa, sb_, ac, pe, ps};
  endfunction

  function automatic logic [14:0] dut_outs();
    return {memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, alucontrol, pcen, pcsrc};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
  endtask

  task automatic push_exp(input string tag, input logic [3:0] st);
    sb.push_back('{tag, st, exp_outs(st, funct, zero)});
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, " state"}, {11'd0, state}, {11'd0, e.st});
    chk({e.tag, " outs"}, dut_outs(), e.outs);
  endtask

  // seq holds up to five expected states, first one in the top nibble.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] fn,
                           input logic z, input int n, input logic [19:0] seq);
    op    = o;
    funct = fn;
    zero  = z;
    for (int i = 0; i < n; i++)
      push_exp($sformatf("%s c%0d", name, i), seq[19-4*i -: 4]);
    while (sb.size() > 0) begin
      pop_check();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b000000;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset held", 4'd0);
    pop_check();
    #4 reset = 1'b0;

    run_instr("lw", 6'b100011, 6'b000000, 1'b0, 5, 20'h01234);
    run_instr("sw", 6'b101011, 6'b000000, 1'b0, 4, 20'h01250);
    run_instr("r_or", 6'b000000, 6'b100101, 1'b0, 4, 20'h01670);
    run_instr("r_add", 6'b000000, 6'b100000, 1'b1, 4, 20'h01670);
    run_instr("r_sub", 6'b000000, 6'b100010, 1'b0, 4, 20'h01670);
    run_instr("r_and", 6'b000000, 6'b100100, 1'b0, 4, 20'h01670);
    run_instr("r_slt", 6'b000000, 6'b101010, 1'b0, 4, 20'h01670);
    run_instr("r_unk", 6'b000000, 6'b111111, 1'b0, 4, 20'h01670);
    run_instr("addi", 6'b001000, 6'b000000, 1'b0, 4, 20'h019A0);
    run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 3, 20'h01800);
    run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 3, 20'h01800);
    run_instr("j", 6'b000010, 6'b000000, 1'b0, 3, 20'h01B00);
    run_instr("op_unk", 6'b111111, 6'b000000, 1'b0, 2, 20'h01000);
`ifdef MC_BNE_EN
    run_instr("bne_z0", 6'b000101, 6'b000000, 1'b0, 3, 20'h01C00);
    run_instr("bne_z1", 6'b000101, 6'b000000, 1'b1, 3, 20'h01C00);
`else
    run_instr("bne_off", 6'b000101, 6'b000000, 1'b0, 2, 20'h01000);
`endif

    // Reset arriving mid-instruction in EXECUTE.
    run_instr("rst_pre", 6'b000000, 6'b100101, 1'b0, 2, 20'h01000);
    push_exp("rst_exec", 4'd6);
    pop_check();
    #2 reset = 1'b1;
    #1;
    push_exp("rst_async", 4'd0);
    pop_check();
    @(posedge clk);
    #1;
    push_exp("rst_hold", 4'd0);
    pop_check();
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    push_exp("rst_release", 4'd1);
    pop_check();
    @(posedge clk);
    #1;
    run_instr("rst_post", 6'b000000, 6'b100101, 1'b0, 3, 20'h67000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; state register updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instr[31:26] from the datapath instruction register.
REQ-005 funct  input  6  instr[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 Outputs SHALL be: memwrite 1, lord 1, irwrite 1, regdst 1, memtoreg 1, regwrite 1, alusrca 1, alusrcb 2, alucontrol 3, pcen 1, pcsrc 2, and state 4 (the current state, for debug).

Function
REQ-008 The block SHALL be a Moore FSM with 4-bit state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-009 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: lw(100011)/sw(101011)->MEMADR; R-type(000000)->EXECUTE; beq(000100)->BRANCH; addi(001000)->ADDIEX; j(000010)->JUMP; any other op->FETCH.
- MEMADR: lw->MEMRD; sw->MEMWR.
- MEMRD->MEMWB.
- EXECUTE->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-010 Every control output not listed for a state SHALL be 0 in that state; aluop defaults to 00.
- FETCH: irwrite=1, alusrcb=01, pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR, ADDIEX: alusrca=1, alusrcb=10.
- MEMRD: lord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: lord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- ADDIWB: regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-011 The ALU decoder SHALL set alucontrol as follows:
- aluop=00: 010 (add).
- aluop=01: 110 (sub).
- aluop=10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct->010.
REQ-012 pcen SHALL be combinational: pcen = pcwrite | (branch & zero).
REQ-013 Every instruction SHALL take a fixed number of cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unrecognised op 2 (FETCH, DECODE).
REQ-014 op SHALL be sampled in DECODE and in MEMADR only; the block SHALL NOT latch op internally.

Reset
REQ-015 Asserting reset SHALL force state to FETCH immediately, including when reset arrives mid-instruction in any state.
REQ-016 While reset is held, outputs SHALL be the FETCH values: irwrite=1, alusrcb=01, alucontrol=010, pcen=1, and all other outputs 0.
REQ-017 After reset deasserts, the first rising edge SHALL move the FSM to DECODE.

Configuration
REQ-018 With the macro MC_BNE_EN defined, the block SHALL support bne:
- DECODE with op 000101 SHALL go to state BRANCHNE=12.
- BRANCHNE SHALL drive the same outputs as BRANCH, except pcen = ~zero.
- BRANCHNE SHALL go to FETCH.
REQ-019 Without MC_BNE_EN, op 000101 SHALL be treated as unrecognised (DECODE->FETCH), and state code 12 SHALL NOT exist.

Structure
REQ-020 A shared package mc_pkg SHALL hold:
- the state enum;
- the opcode constants;
- the funct constants;
- the alucontrol constants;
- the aluop constants.
REQ-021 ALU decoding SHALL be in one sub-module, mc_aludec (aluop and funct in, alucontrol out).
REQ-022 The state register SHALL be the only sequential element.

Verification
REQ-023 Reset in EXECUTE: assert reset while state=6 -> state=0 immediately, irwrite=1, pcen=1; release reset -> state=1 on the next edge.
REQ-024 lw (op=100011) -> states 0,1,2,3,4,0; lord=1 in state 3; regwrite=1 and memtoreg=1 in state 4.
REQ-025 R-type or (funct=100101) -> states 0,1,6,7,0; alucontrol=001 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-026 beq (op=000100): zero=1 -> pcen=1 and pcsrc=01 in state 8; zero=0 -> pcen=0; both cases return to state 0.
REQ-027 j (op=000010) -> states 0,1,11,0 with pcsrc=10 and pcen=1 in state 11; op=111111 -> 0,1,0.
REQ-028 With MC_BNE_EN, op=000101 and zero=0 -> state 12 with pcen=1; without MC_BNE_EN -> states 0,1,0.
